rmw_sequencer: RTL

//  Drives 6502 read-modify-write memory instructions (ASL/ROL/LSR/ROR/INC/DEC on memory) around the combinational ALU.

---
 rtl/rmw_sequencer_if.sv | 39 +++
 rtl/rmw_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rmw_sequencer_if.sv
// Bus bundle between the RMW sequencer, the address-generation stage,
// the memory bus, the ALU and the P register.
interface rmw_sequencer_if #(
  parameter int AW = 16
);
  logic          start;
  logic [AW-1:0] ea;
  logic [3:0]    mode;
  logic [7:0]    p_in;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_we;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_ready;
  logic [3:0]    alu_mode;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [7:0]    alu_p;
  logic [7:0]    alu_ar;
  logic [7:0]    alu_af;
  logic [7:0]    p_out;
  logic          p_we;

  modport master (
    output start, ea, mode, p_in, mem_din, mem_ready, alu_ar, alu_af,
    input  busy, done, err, mem_addr, mem_rd, mem_we, mem_dout,
           alu_mode, alu_a, alu_b, alu_p, p_out, p_we
  );

  modport slave (
    input  start, ea, mode, p_in, mem_din, mem_ready, alu_ar, alu_af,
    output busy, done, err, mem_addr, mem_rd, mem_we, mem_dout,
           alu_mode, alu_a, alu_b, alu_p, p_out, p_we
  );
endinterface

// File: rtl/rmw_sequencer.sv
// Read-modify-write sequencer for 6502 memory shift/inc/dec instructions.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; illegal mode gives a one-cycle err
// READ  | reading operand at ea
// DUMMY | writing unmodified operand back; ALU result captured here
// WRITE | writing ALU result to ea
// DONE  | one-cycle done pulse, P register update
module rmw_sequencer #(
  parameter int AW          = 16,
  parameter int DUMMY_WRITE = 1
) (
  input  logic            clk,
  input  logic            rst,
  rmw_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DUMMY,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ea_q;
  logic [3:0]    mode_q;
  logic [7:0]    p_q;
  logic [7:0]    opnd;
  logic [7:0]    res;
  logic [7:0]    flg;
  logic          err_q;
  logic          wr_first;
  logic          legal;

  // Only the six memory RMW ALU modes are accepted.
  always_comb begin
    legal = bus.mode inside {4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1110, 4'b1111};
  end

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; mem_ready=0 holds every bus state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start && legal) state_nxt = S_READ;
      S_READ:  if (bus.mem_ready) state_nxt = (DUMMY_WRITE != 0) ? S_DUMMY : S_WRITE;
      S_DUMMY: if (bus.mem_ready) state_nxt = S_WRITE;
      S_WRITE: if (bus.mem_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/result/flag registers and the err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_q     <= '0;
      mode_q   <= '0;
      p_q      <= '0;
      opnd     <= '0;
      res      <= '0;
      flg      <= '0;
      err_q    <= 1'b0;
      wr_first <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (legal) begin
              ea_q   <= bus.ea;
              mode_q <= bus.mode;
              p_q    <= bus.p_in;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (bus.mem_ready) begin
            opnd     <= bus.mem_din;
            // Without a dummy cycle the ALU is first valid in WRITE.
            wr_first <= (DUMMY_WRITE == 0);
          end
        end
        S_DUMMY: begin
          res <= bus.alu_ar;
          flg <= bus.alu_af;
        end
        S_WRITE: begin
          if (wr_first) begin
            res      <= bus.alu_ar;
            flg      <= bus.alu_af;
            wr_first <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; bus fields are zero outside the access states.
  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.done     = (state == S_DONE);
    bus.p_we     = (state == S_DONE);
    bus.p_out    = (state == S_DONE) ? flg : 8'h00;
    bus.err      = err_q;
    bus.mem_rd   = (state == S_READ);
    bus.mem_we   = (state == S_DUMMY) || (state == S_WRITE);
    bus.mem_addr = '0;
    bus.mem_dout = 8'h00;
    bus.alu_mode = mode_q;
    bus.alu_a    = 8'h00;
    bus.alu_b    = opnd;
    bus.alu_p    = p_q;
    case (state)
      S_READ:  bus.mem_addr = ea_q;
      S_DUMMY: begin
        bus.mem_addr = ea_q;
        bus.mem_dout = opnd;
      end
      S_WRITE: begin
        bus.mem_addr = ea_q;
        bus.mem_dout = wr_first ? bus.alu_ar : res;
      end
      default: ;
    endcase
  end

endmodule
